wb_host_master: RTL and testbench
=================================

# wb_host_master

Wishbone classic-cycle bus initiator that drives the USB core's Wishbone slave port from the opposite end. It accepts single read/write commands on a valid/ready command channel, runs exactly one Wishbone cycle per command, and returns read data and status on a valid/ready response channel. Used by the on-chip self-test sequencer and by simulation harnesses that need a synthesizable bus driver in place of external stimulus. A bus watchdog ends any cycle the slave never acknowledges.

## Interface
- TIMEOUT, 255: number of cycles with stb high and no ack/err before the master aborts; 0 disables the watchdog.
- clk48  input  1  sole clock; every register is clocked on its rising edge.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  high only in IDLE.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_adr  input  30  word address.
- cmd_dat  input  32  write data.
- cmd_sel  input  4  byte lanes.
- rsp_valid  output  1  a response is presented.
- rsp_ready  input  1  the consumer accepts the response.
- rsp_dat  output  32  read data; 0 for writes and for aborted cycles.
- rsp_err  output  1  slave err or watchdog abort.
- rsp_timeout  output  1  watchdog abort only.
- wishbone_adr  output  30; wishbone_datwr  output  32; wishbone_sel  output  4; wishbone_we  output  1; wishbone_cyc  output  1; wishbone_stb  output  1.
- wishbone_cti  output  3  tied to 3'b000 (classic cycle).
- wishbone_bte  output  2  tied to 2'b00 (linear burst type).
- wishbone_datrd  input  32; wishbone_ack  input  1; wishbone_err  input  1.

## Operation
- Three states: IDLE, BUS, RESP. Every output is registered except cmd_ready, which is decoded from the state.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch we/adr/dat/sel onto the wishbone_* outputs, set cyc=stb=1, clear the watchdog counter, go to BUS.
- BUS:
  - Outputs hold stable; cmd_ready=0.
  - Each cycle the master samples ack and err. err has priority over ack when both are high.
  - ack: capture wishbone_datrd into rsp_dat (reads only; writes load 0), set rsp_err=0 and rsp_timeout=0, drop cyc/stb, go to RESP.
  - err: rsp_dat=0, rsp_err=1, rsp_timeout=0, drop cyc/stb, go to RESP.
  - Neither, with TIMEOUT≠0: increment the counter. When the counter equals TIMEOUT-1 in a cycle with no ack/err, abort: rsp_err=1, rsp_timeout=1, rsp_dat=0, drop cyc/stb, go to RESP.
  - Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.
- RESP:
  - rsp_valid=1. rsp_dat, rsp_err and rsp_timeout hold until rsp_valid&rsp_ready.
  - On acceptance: rsp_valid=0, go to IDLE.
  - No new command is accepted in the same cycle as a response is consumed.
- wishbone_adr, wishbone_datwr, wishbone_sel and wishbone_we hold their last values after a cycle ends. The slave ignores them while cyc=0.

## Timing
- Reset values: state=IDLE, cyc=stb=we=0, adr=0, datwr=0, sel=0, rsp_valid=0, rsp_dat=0, rsp_err=0, rsp_timeout=0, counter=0. cmd_ready=1 immediately after reset_n deasserts.
- Command accepted at edge T: cyc/stb are high from T+1.
- Slave asserts ack in the cycle sampled at edge T+k (k≥1): cyc/stb are low and rsp_valid is high from T+k+1. For a zero-wait-state slave (ack in the first stb cycle), the command-to-response latency is 2 cycles.
- stb is high for exactly k cycles per cycle. The master never issues back-to-back cycles; there is at least 2 cycles of cyc=0 between cycles (RESP, then IDLE).
- Watchdog: with no ack/err, stb is high for exactly TIMEOUT cycles. rsp_valid rises on the edge after the last of them.
- An ack or err arriving while cyc=0 (late slave) is ignored and does not affect rsp_* or the state.
- reset_n asserted mid-cycle clears cyc/stb asynchronously, discards the in-flight command, and drops rsp_valid. No response is produced for that command.

## Test plan
- Zero-wait read: cmd adr=0x100, we=0; slave acks in the first stb cycle with datrd=0xDEADBEEF -> cyc high exactly 1 cycle; rsp_valid 2 cycles after acceptance; rsp_dat=0xDEADBEEF; rsp_err=0.
- Write with 3 wait states: cmd we=1, dat=0x12345678, sel=4'b0011 -> bus fields stable for 4 stb cycles; rsp_dat=0; rsp_err=0.
- Slave err, with ack high in the same cycle: rsp_err=1, rsp_timeout=0, rsp_dat=0.
- Watchdog with TIMEOUT=8 and a silent slave -> stb high exactly 8 cycles; rsp_err=1, rsp_timeout=1. A late ack afterwards is ignored.
- Response backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid high -> cmd_ready stays 0 and rsp_* stay stable. Next command is accepted 1 cycle after rsp_ready rises.
- Asynchronous reset_n pulse in the middle of BUS -> cyc/stb low without waiting for a clock edge; rsp_valid=0; cmd_ready=1 after release; the next command runs normally.

Source files
------------

// File: rtl/wb_host_master.sv
// Wishbone classic-cycle initiator: one bus cycle per command on a valid/ready
// channel, response returned on a second valid/ready channel, with a bus watchdog.
module wb_host_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk48,
    input  logic        reset_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [29:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_timeout,

    output logic [29:0] wishbone_adr,
    output logic [31:0] wishbone_datwr,
    output logic [3:0]  wishbone_sel,
    output logic        wishbone_we,
    output logic        wishbone_cyc,
    output logic        wishbone_stb,
    output logic [2:0]  wishbone_cti,
    output logic [1:0]  wishbone_bte,
    input  logic [31:0] wishbone_datrd,
    input  logic        wishbone_ack,
    input  logic        wishbone_err
);

    // Keep a 1-bit counter when the watchdog is disabled so the width is never zero.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [29:0]   adr_q, adr_d;
    logic [31:0]   datwr_q, datwr_d;
    logic [3:0]    sel_q, sel_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cyc_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            datwr_q       <= '0;
            sel_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_dat_q     <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            we_q          <= we_d;
            adr_q         <= adr_d;
            datwr_q       <= datwr_d;
            sel_q         <= sel_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_dat_q     <= rsp_dat_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        we_d          = we_q;
        adr_d         = adr_q;
        datwr_d       = datwr_q;
        sel_d         = sel_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_dat_d     = rsp_dat_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_cnt_d      = wd_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d     = cmd_we;
                    adr_d    = cmd_adr;
                    datwr_d  = cmd_dat;
                    sel_d    = cmd_sel;
                    cyc_d    = 1'b1;
                    wd_cnt_d = '0;
                    state_d  = BUS;
                end
            end
            BUS: begin
                // err wins over ack when a slave raises both.
                if (wishbone_err) begin
                    rsp_dat_d     = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    cyc_d         = 1'b0;
                    state_d       = RESP;
                end else if (wishbone_ack) begin
                    rsp_dat_d     = we_q ? '0 : wishbone_datrd;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    cyc_d         = 1'b0;
                    state_d       = RESP;
                end else if (TIMEOUT != 0) begin
                    if (wd_cnt_q == WD_LAST) begin
                        rsp_dat_d     = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        cyc_d         = 1'b0;
                        state_d       = RESP;
                    end else if (wd_cnt_q != '1) begin
                        wd_cnt_d = wd_cnt_q + CW'(1);
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready      = (state_q == IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_dat        = rsp_dat_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign wishbone_adr   = adr_q;
    assign wishbone_datwr = datwr_q;
    assign wishbone_sel   = sel_q;
    assign wishbone_we    = we_q;
    assign wishbone_cyc   = cyc_q;
    assign wishbone_stb   = cyc_q;
    assign wishbone_cti   = 3'b000;
    assign wishbone_bte   = 2'b00;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed self-checking bench for wb_host_master with the watchdog set to 8 cycles.
module tb_wb_host_master;

    logic        clk48 = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [29:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_dat;
    logic [29:0] wishbone_adr;
    logic [31:0] wishbone_datwr, wishbone_datrd;
    logic [3:0]  wishbone_sel;
    logic        wishbone_we, wishbone_cyc, wishbone_stb, wishbone_ack, wishbone_err;
    logic [2:0]  wishbone_cti;
    logic [1:0]  wishbone_bte;

    int n_checks = 0;
    int n_fails  = 0;
    int stb_cnt;

    always #5 clk48 = ~clk48;

    wb_host_master #(.TIMEOUT(8)) dut (
        .clk48          (clk48),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_we         (cmd_we),
        .cmd_adr        (cmd_adr),
        .cmd_dat        (cmd_dat),
        .cmd_sel        (cmd_sel),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_dat        (rsp_dat),
        .rsp_err        (rsp_err),
        .rsp_timeout    (rsp_timeout),
        .wishbone_adr   (wishbone_adr),
        .wishbone_datwr (wishbone_datwr),
        .wishbone_sel   (wishbone_sel),
        .wishbone_we    (wishbone_we),
        .wishbone_cyc   (wishbone_cyc),
        .wishbone_stb   (wishbone_stb),
        .wishbone_cti   (wishbone_cti),
        .wishbone_bte   (wishbone_bte),
        .wishbone_datrd (wishbone_datrd),
        .wishbone_ack   (wishbone_ack),
        .wishbone_err   (wishbone_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; wishbone_datrd = '0; wishbone_ack = 1'b0;
        wishbone_err = 1'b0;
        #23 reset_n = 1'b1;
        tick();

        // Reset state
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_cyc", {31'd0, wishbone_cyc}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_dat", rsp_dat, 32'd0);
        check("rst_adr", {2'b0, wishbone_adr}, 32'd0);
        check("rst_cti_bte", {27'd0, wishbone_cti, wishbone_bte}, 32'd0);

        // Zero-wait read
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 30'h100; cmd_sel = 4'hF;
        tick();
        check("rd_cyc", {31'd0, wishbone_cyc}, 32'd1);
        check("rd_stb", {31'd0, wishbone_stb}, 32'd1);
        check("rd_adr", {2'b0, wishbone_adr}, 32'h100);
        check("rd_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0; wishbone_ack = 1'b1; wishbone_datrd = 32'hDEADBEEF;
        tick();
        wishbone_ack = 1'b0;
        check("rd_cyc_drop", {31'd0, wishbone_cyc}, 32'd0);
        check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd_rsp_dat", rsp_dat, 32'hDEADBEEF);
        check("rd_rsp_err", {31'd0, rsp_err}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("rd_done_ready", {31'd0, cmd_ready}, 32'd1);

        // Write with 3 wait states
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 30'h2A; cmd_dat = 32'h12345678; cmd_sel = 4'b0011;
        tick();
        cmd_valid = 1'b0; cmd_dat = 32'h0; cmd_sel = 4'h0; wishbone_datrd = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) wishbone_ack = 1'b1;
            check("wr_stb", {31'd0, wishbone_stb}, 32'd1);
            check("wr_datwr", wishbone_datwr, 32'h12345678);
            check("wr_sel_we_adr", {wishbone_sel, wishbone_we, 27'd0}, {4'b0011, 1'b1, 27'd0});
            check("wr_adr", {2'b0, wishbone_adr}, 32'h2A);
            tick();
        end
        wishbone_ack = 1'b0;
        check("wr_stb_drop", {31'd0, wishbone_stb}, 32'd0);
        check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr_rsp_dat", rsp_dat, 32'd0);
        check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("wr_hold_datwr", wishbone_datwr, 32'h12345678);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Slave err together with ack
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 30'h44;
        tick();
        cmd_valid = 1'b0; wishbone_ack = 1'b1; wishbone_err = 1'b1; wishbone_datrd = 32'hAAAA5555;
        tick();
        wishbone_ack = 1'b0; wishbone_err = 1'b0;
        check("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("err_rsp_err", {31'd0, rsp_err}, 32'd1);
        check("err_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        check("err_rsp_dat", rsp_dat, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Watchdog with a silent slave
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 30'h60;
        tick();
        cmd_valid = 1'b0;
        stb_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!wishbone_stb) break;
            stb_cnt++;
            tick();
        end
        check("wd_stb_cycles", stb_cnt, 32'd8);
        check("wd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wd_rsp_err", {31'd0, rsp_err}, 32'd1);
        check("wd_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
        check("wd_rsp_dat", rsp_dat, 32'd0);
        wishbone_ack = 1'b1; wishbone_datrd = 32'h00000123;
        tick();
        check("late_ack_dat", rsp_dat, 32'd0);
        check("late_ack_flags", {30'd0, rsp_err, rsp_timeout}, 32'd3);
        check("late_ack_valid", {31'd0, rsp_valid}, 32'd1);
        check("late_ack_cyc", {31'd0, wishbone_cyc}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        wishbone_ack = 1'b0;
        check("late_ack_idle_valid", {31'd0, rsp_valid}, 32'd0);
        check("late_ack_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // Response backpressure with a command waiting
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 30'h10;
        tick();
        cmd_adr = 30'h55; wishbone_ack = 1'b1; wishbone_datrd = 32'hCAFEF00D;
        tick();
        wishbone_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_dat", rsp_dat, 32'hCAFEF00D);
            check("bp_cyc", {31'd0, wishbone_cyc}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_release_cyc", {31'd0, wishbone_cyc}, 32'd0);
        check("bp_release_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("bp_next_cyc", {31'd0, wishbone_cyc}, 32'd1);
        check("bp_next_adr", {2'b0, wishbone_adr}, 32'h55);
        wishbone_ack = 1'b1; wishbone_datrd = 32'h00000011;
        tick();
        wishbone_ack = 1'b0;
        check("bp_next_dat", rsp_dat, 32'h11);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Asynchronous reset in the middle of BUS
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 30'h77;
        tick();
        cmd_valid = 1'b0;
        check("ar_cyc_before", {31'd0, wishbone_cyc}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("ar_cyc", {31'd0, wishbone_cyc}, 32'd0);
        check("ar_stb", {31'd0, wishbone_stb}, 32'd0);
        check("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        #2 reset_n = 1'b1;
        tick();
        check("ar_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("ar_no_rsp", {31'd0, rsp_valid}, 32'd0);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 30'h3; cmd_dat = 32'hA5A5A5A5; cmd_sel = 4'hF;
        tick();
        cmd_valid = 1'b0;
        check("ar_next_datwr", wishbone_datwr, 32'hA5A5A5A5);
        check("ar_next_cyc", {31'd0, wishbone_cyc}, 32'd1);
        wishbone_ack = 1'b1;
        tick();
        wishbone_ack = 1'b0;
        check("ar_next_rsp", {rsp_valid, rsp_err, rsp_timeout, 29'd0}, {3'b100, 29'd0});
        check("ar_next_dat", rsp_dat, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("ar_final_ready", {31'd0, cmd_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
